palette_arbiter: RTL and testbench

PALETTE_ARBITER -- requirements
Module: palette_arbiter

---
 rtl/video_pkg.sv | 34 +++
 rtl/palette_arbiter_if.sv | 23 ++
 rtl/palette_cpu_port.sv | 76 +++++++
 rtl/palette_arbiter.sv | 125 ++++++++++++
 tb/tb_palette_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared video/palette constants: bus widths, hscale codes, CPU port FSM states.
// Helper rep_mask() turns a scale code into the pixel-repeat counter mask.
package video_pkg;

    localparam int PAL_AW = 8;
    localparam int PAL_DW = 12;
    localparam int LB_AW  = 10;

    localparam logic [1:0] HSCALE_X1 = 2'd0;
    localparam logic [1:0] HSCALE_X2 = 2'd1;
    localparam logic [1:0] HSCALE_X4 = 2'd2;
    localparam logic [1:0] HSCALE_X8 = 2'd3;

    typedef logic [1:0] cpu_state_t;

    localparam cpu_state_t CPU_IDLE   = 2'd0;
    localparam cpu_state_t CPU_PEND   = 2'd1;
    localparam cpu_state_t CPU_RDWAIT = 2'd2;
    localparam cpu_state_t CPU_ACK    = 2'd3;

    function automatic logic [2:0] rep_mask(input logic [1:0] scale);
        logic [2:0] m;
        m = 3'd0;
        unique case (scale)
            HSCALE_X1: m = 3'd0;
            HSCALE_X2: m = 3'd1;
            HSCALE_X4: m = 3'd3;
            HSCALE_X8: m = 3'd7;
            default:   m = 3'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/palette_arbiter_if.sv
// CPU palette access bus.
// master: cpu_req/cpu_we/cpu_addr/cpu_wdata out, cpu_ack/cpu_rdata in; slave mirrors.
interface palette_arbiter_if;
    import video_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [PAL_AW-1:0] cpu_addr;
    logic [PAL_DW-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [PAL_DW-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );

endinterface

// File: rtl/palette_cpu_port.sv
// CPU-side palette handshake FSM: latches a request, waits for a free port.
// Ports: clk, rst_n, port_free, pal_rdata, cpu (slave), drv_* port request.
module palette_cpu_port
    import video_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              port_free,
    input  logic [PAL_DW-1:0] pal_rdata,
    palette_arbiter_if.slave  cpu,
    output logic              drv_en,
    output logic              drv_we,
    output logic [PAL_AW-1:0] drv_addr,
    output logic [PAL_DW-1:0] drv_wdata
);

    cpu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [PAL_AW-1:0] addr_q, addr_d;
    logic [PAL_DW-1:0] wdata_q, wdata_d;
    logic [PAL_DW-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        drv_en  = 1'b0;
        unique case (state_q)
            CPU_IDLE: begin
                if (cpu.cpu_req) begin
                    we_d    = cpu.cpu_we;
                    addr_d  = cpu.cpu_addr;
                    wdata_d = cpu.cpu_wdata;
                    state_d = CPU_PEND;
                end
            end
            CPU_PEND: begin
                if (port_free) begin
                    drv_en  = 1'b1;
                    state_d = we_q ? CPU_ACK : CPU_RDWAIT;
                end
            end
            CPU_RDWAIT: begin
                rdata_d = pal_rdata;
                state_d = CPU_ACK;
            end
            CPU_ACK: state_d = CPU_IDLE;
            default: state_d = CPU_IDLE;
        endcase
    end

    assign drv_we        = drv_en & we_q;
    assign drv_addr      = addr_q;
    assign drv_wdata     = wdata_q;
    assign cpu.cpu_ack   = (state_q == CPU_ACK);
    assign cpu.cpu_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CPU_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/palette_arbiter.sv
// Video palette lookup pipeline sharing one palette RAM port with the CPU.
// Ports: clk, rst_n, vid_* timing, linebuf_*, pal_* RAM port, rgb out, cpu bus.
module palette_arbiter
    import video_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_next_line,
    input  logic              vid_next_pixel,
    input  logic [1:0]        vid_hscale,
    output logic [LB_AW-1:0]  linebuf_addr,
    input  logic [PAL_AW-1:0] linebuf_data,
    output logic [PAL_AW-1:0] pal_addr,
    output logic              pal_wr,
    output logic [PAL_DW-1:0] pal_wdata,
    input  logic [PAL_DW-1:0] pal_rdata,
    output logic [PAL_DW-1:0] palette_rgb_data,
    palette_arbiter_if.slave  cpu
);

    logic [1:0]        scale_q, scale_d;
    logic [2:0]        rep_q, rep_d;
    logic [LB_AW-1:0]  lb_addr_q, lb_addr_d;
    logic              fetch1_q, fetch1_d;
    logic              fetch2_q, fetch2_d;
    logic              pix1_q, pix1_d;
    logic              pix2_q, pix2_d;
    logic [PAL_DW-1:0] colour_q, colour_d;
    logic [PAL_DW-1:0] rgb_q, rgb_d;
    logic [PAL_AW-1:0] pal_addr_q, pal_addr_d;

    logic [1:0]        scale_cur;
    logic [2:0]        rep_cur, rep_nxt;
    logic [LB_AW-1:0]  addr_cur;
    logic              fetch;
    logic              port_free;
    logic              drv_en, drv_we;
    logic [PAL_AW-1:0] drv_addr;

    // A line restart takes effect in its own cycle so a coincident
    // pixel already fetches address 0 at the new scale.
    always_comb begin
        scale_cur = vid_next_line ? vid_hscale : scale_q;
        rep_cur   = vid_next_line ? 3'd0 : rep_q;
        addr_cur  = vid_next_line ? '0 : lb_addr_q;
        fetch     = vid_next_pixel && (rep_cur == 3'd0);
        rep_nxt   = (rep_cur + 3'd1) & rep_mask(scale_cur);
        scale_d   = scale_cur;
        rep_d     = rep_cur;
        lb_addr_d = addr_cur;
        if (vid_next_pixel) begin
            rep_d = rep_nxt;
            if (rep_nxt == 3'd0) begin
                lb_addr_d = addr_cur + 10'd1;
            end
        end
    end

    assign linebuf_addr = addr_cur;

    // t+1 owns the port, t+2 sees RAM data, t+3 shows the registered pixel.
    always_comb begin
        fetch1_d = fetch;
        pix1_d   = vid_next_pixel;
        fetch2_d = fetch1_q;
        pix2_d   = pix1_q;
        colour_d = fetch2_q ? pal_rdata : colour_q;
        rgb_d    = pix2_q ? colour_d : '0;
    end

    assign port_free = !fetch1_q;

    palette_cpu_port u_cpu_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .port_free (port_free),
        .pal_rdata (pal_rdata),
        .cpu       (cpu),
        .drv_en    (drv_en),
        .drv_we    (drv_we),
        .drv_addr  (drv_addr),
        .drv_wdata (pal_wdata)
    );

    always_comb begin
        pal_addr = pal_addr_q;
        pal_wr   = 1'b0;
        if (fetch1_q) begin
            pal_addr = linebuf_data;
        end else if (drv_en) begin
            pal_addr = drv_addr;
            pal_wr   = drv_we;
        end
        pal_addr_d = pal_addr;
    end

    assign palette_rgb_data = rgb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q    <= HSCALE_X1;
            rep_q      <= 3'd0;
            lb_addr_q  <= '0;
            fetch1_q   <= 1'b0;
            fetch2_q   <= 1'b0;
            pix1_q     <= 1'b0;
            pix2_q     <= 1'b0;
            colour_q   <= '0;
            rgb_q      <= '0;
            pal_addr_q <= '0;
        end else begin
            scale_q    <= scale_d;
            rep_q      <= rep_d;
            lb_addr_q  <= lb_addr_d;
            fetch1_q   <= fetch1_d;
            fetch2_q   <= fetch2_d;
            pix1_q     <= pix1_d;
            pix2_q     <= pix2_d;
            colour_q   <= colour_d;
            rgb_q      <= rgb_d;
            pal_addr_q <= pal_addr_d;
        end
    end

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter with line-buffer and palette RAM models.
// Expected pixels are queued at drive time and popped three cycles later.
module tb_palette_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_next_line;
    logic        vid_next_pixel;
    logic [1:0]  vid_hscale;
    logic [9:0]  linebuf_addr;
    logic [7:0]  linebuf_data;
    logic [7:0]  pal_addr;
    logic        pal_wr;
    logic [11:0] pal_wdata;
    logic [11:0] pal_rdata;
    logic [11:0] palette_rgb_data;

    palette_arbiter_if bus ();

    palette_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .vid_next_line    (vid_next_line),
        .vid_next_pixel   (vid_next_pixel),
        .vid_hscale       (vid_hscale),
        .linebuf_addr     (linebuf_addr),
        .linebuf_data     (linebuf_data),
        .pal_addr         (pal_addr),
        .pal_wr           (pal_wr),
        .pal_wdata        (pal_wdata),
        .pal_rdata        (pal_rdata),
        .palette_rgb_data (palette_rgb_data),
        .cpu              (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  lb_mem  [1024];
    logic [11:0] pal_mem [256];
    logic [11:0] pal_sh  [256];
    bit          pal_init = 1'b0;

    always @(posedge clk) begin
        linebuf_data <= lb_mem[linebuf_addr];
        if (!pal_init) begin
            for (int i = 0; i < 256; i++) begin
                pal_mem[i] <= {i[3:0], i[3:0], i[3:0]};
            end
            pal_init <= 1'b1;
        end else if (pal_wr) begin
            pal_mem[pal_addr] <= pal_wdata;
        end
        pal_rdata <= pal_mem[pal_addr];
    end

    typedef struct {
        int          due;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int          cyc = 0;
    int          m_rep, m_addr, m_scale;
    logic [11:0] m_col;
    bit          m_f1;
    logic [7:0]  m_f1_idx;
    logic [7:0]  m_pal_addr;
    int          last_f1_cyc = -100;

    int          pend = 0;
    logic [7:0]  p_addr;
    logic [11:0] p_data;
    int          req_cyc = -1;
    int          wr_cyc = -1;
    int          ack_cyc = -1;
    int          n_ack = 0;
    int          last_pix;
    int          acks_before;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rep      = 0;
        m_addr     = 0;
        m_scale    = 0;
        m_col      = '0;
        m_f1       = 1'b0;
        m_pal_addr = '0;
        pend       = 0;
        exp_q.delete();
    endtask

    task automatic req(input bit we, input logic [7:0] a,
                       input logic [11:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = we ? d : 12'h000;
        pend          = we ? 1 : 2;
        p_addr        = a;
        p_data        = d;
        req_cyc       = cyc;
        if (we) pal_sh[a] = d;
    endtask

    task automatic px(input bit pix, input bit line, input logic [1:0] hs);
        exp_t e;
        int   rep_e, addr_e, sc_e, rn;
        vid_next_pixel = pix;
        vid_next_line  = line;
        vid_hscale     = hs;
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rgb", palette_rgb_data, e.rgb);
        end
        if (m_f1) begin
            chk("vid_pal_addr", pal_addr, m_f1_idx);
            chk("vid_pal_wr", pal_wr, 1'b0);
            m_pal_addr  = m_f1_idx;
            last_f1_cyc = cyc;
        end else if (pal_wr) begin
            chk("wr_expected", pend, 1);
            chk("wr_addr", pal_addr, p_addr);
            chk("wr_data", pal_wdata, p_data);
            wr_cyc     = cyc;
            m_pal_addr = p_addr;
        end else if (pend == 0) begin
            chk("idle_pal_addr", pal_addr, m_pal_addr);
        end
        if (bus.cpu_ack) begin
            n_ack++;
            ack_cyc = cyc;
            chk("ack_expected", pend != 0, 1);
            if (pend == 2) begin
                chk("rd_data", bus.cpu_rdata, p_data);
                if (last_f1_cyc < cyc - 2) m_pal_addr = p_addr;
            end
            if (pend == 1) chk("ack_after_wr", cyc, wr_cyc + 1);
            pend = 0;
        end
        rep_e  = line ? 0 : m_rep;
        addr_e = line ? 0 : m_addr;
        sc_e   = line ? int'(hs) : m_scale;
        chk("lb_addr", linebuf_addr, addr_e);
        m_f1 = 1'b0;
        if (pix) begin
            if (rep_e == 0) begin
                m_f1     = 1'b1;
                m_f1_idx = lb_mem[addr_e];
                m_col    = pal_sh[m_f1_idx];
            end
            exp_q.push_back('{cyc + 3, m_col});
            rn = (rep_e + 1) % (1 << sc_e);
            if (rn == 0) addr_e = (addr_e + 1) % 1024;
            rep_e = rn;
        end else begin
            exp_q.push_back('{cyc + 3, 12'h000});
        end
        m_rep   = rep_e;
        m_addr  = addr_e;
        m_scale = sc_e;
        @(posedge clk);
        cyc++;
        #1;
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        vid_next_line  = 1'b0;
        vid_next_pixel = 1'b0;
        vid_hscale     = 2'd0;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        for (int i = 0; i < 1024; i++) lb_mem[i] = i[7:0];
        for (int i = 0; i < 256; i++) pal_sh[i] = {i[3:0], i[3:0], i[3:0]};
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_lb_addr", linebuf_addr, 0);
        chk("rst_rgb", palette_rgb_data, 0);
        chk("rst_pal_addr", pal_addr, 0);
        chk("rst_pal_wr", pal_wr, 0);
        chk("rst_pal_wdata", pal_wdata, 0);
        chk("rst_ack", bus.cpu_ack, 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        repeat (3) px(0, 0, 2'd0);

        // x1 line with a CPU write issued mid-line
        px(0, 1, 2'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) req(1, 8'd5, 12'hABC);
            px(1, 0, 2'd0);
        end
        last_pix = cyc - 1;
        repeat (8) px(0, 0, 2'd0);
        chk("wr_slot", wr_cyc, last_pix + 2);
        chk("wr_acks", n_ack, 1);

        // x1 line reading back the rewritten entry
        px(0, 1, 2'd0);
        for (int i = 0; i < 8; i++) px(1, 0, 2'd0);
        repeat (5) px(0, 0, 2'd0);

        // x2 line
        px(0, 1, 2'd1);
        for (int i = 0; i < 8; i++) px(1, 0, 2'd0);
        repeat (5) px(0, 0, 2'd0);

        // x4 line with a CPU read
        px(0, 1, 2'd2);
        for (int i = 0; i < 16; i++) begin
            if (i == 2) req(0, 8'd5, pal_sh[5]);
            px(1, 0, 2'd0);
        end
        last_pix = cyc - 1;
        chk("rd_acks", n_ack, 2);
        chk("rd_latency", (ack_cyc - req_cyc) <= 4, 1);
        chk("rd_in_line", ack_cyc <= last_pix, 1);
        repeat (5) px(0, 0, 2'd0);

        // restart coincident with a pixel at address 37
        px(0, 1, 2'd0);
        for (int i = 0; i < 37; i++) px(1, 0, 2'd0);
        px(1, 1, 2'd0);
        for (int i = 0; i < 3; i++) px(1, 0, 2'd0);
        repeat (5) px(0, 0, 2'd0);

        // reset while the read sits in RDWAIT
        req(0, 8'd9, pal_sh[9]);
        px(0, 0, 2'd0);
        px(0, 0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lb_addr", linebuf_addr, 0);
        chk("arst_rgb", palette_rgb_data, 0);
        chk("arst_pal_addr", pal_addr, 0);
        chk("arst_pal_wr", pal_wr, 0);
        chk("arst_pal_wdata", pal_wdata, 0);
        chk("arst_ack", bus.cpu_ack, 0);
        chk("arst_rdata", bus.cpu_rdata, 0);
        model_reset();
        acks_before = n_ack;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        repeat (10) px(0, 0, 2'd0);
        chk("no_ack_after_rst", n_ack, acks_before);

        // pipeline restarts cleanly after reset
        px(0, 1, 2'd0);
        for (int i = 0; i < 4; i++) px(1, 0, 2'd0);
        repeat (5) px(0, 0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
